scarf_sram_arbiter: RTL and testbench
=====================================

SCARF_SRAM_ARBITER -- requirements
Module: scarf_sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 4, giving the SRAM strobe width in clk cycles; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the board clock (100 MHz domain).
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req, input, [2:0], one bit per requester: 0 = pattern generator, 1 = SCARF ext-SRAM slave, 2 = spare/capture.
REQ-005 SHALL have port req_rnw, input, [2:0]; 1 = read, 0 = write, one bit per requester.
REQ-006 SHALL have port req_addr, input, [2:0][18:0], the address for each requester.
REQ-007 SHALL have port req_wdata, input, [2:0][7:0], the write data for each requester.
REQ-008 SHALL have port gnt, output, [2:0]; one-hot, one-cycle pulse marking the cycle a request is accepted.
REQ-009 SHALL have port done, output, [2:0]; one-hot, one-cycle pulse marking completion of the granted transaction.
REQ-010 SHALL have port rdata, output, [7:0]; read data, valid in the cycle done is high for a read.
REQ-011 SHALL have port sram_din, input, [7:0], data from the top-level inout pad.
REQ-012 SHALL have port sram_dout, output, [7:0], write data to the pad.
REQ-013 SHALL have port sram_dout_en, output, 1; when high, the top level drives sram_dout onto the pad.
REQ-014 SHALL have ports sram_addr (output, [18:0]) and sram_cen, sram_oen, sram_wen (outputs, 1 each, active-low).
REQ-015 SHALL have port busy, output, 1; high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, SETUP, ACCESS and HOLD.
REQ-017 SHALL arbitrate only in IDLE or HOLD. Requester 0 has absolute priority. Requesters 1 and 2 alternate by round-robin pointer, which updates only when requester 1 or 2 is granted.
REQ-018 SHALL assert gnt combinationally in the arbitration cycle and register rnw, addr and wdata on that edge. The requester keeps req, addr and wdata stable until it sees gnt. A req still high after gnt is a new request.
REQ-019 SHALL move to SETUP after a grant and stay in IDLE with no grant. In SETUP, for 1 cycle: sram_cen=0, sram_addr valid, sram_oen=sram_wen=1.
REQ-020 SHALL hold ACCESS for exactly ACCESS_CYCLES cycles, timed by a 4-bit down-counter.
- Read: sram_oen=0 throughout ACCESS; sram_din is captured into rdata on the last ACCESS cycle.
- Write: sram_wen=0 and sram_dout_en=1 throughout ACCESS.
REQ-021 SHALL make HOLD 1 cycle: sram_cen=0, sram_oen=sram_wen=1, sram_dout_en held high for a write (data hold), done pulses for the owner. A grant in HOLD goes to SETUP; otherwise the next state is IDLE.
REQ-022 SHALL give gnt-to-done latency of ACCESS_CYCLES+2 cycles. Back-to-back throughput SHALL be one transaction per ACCESS_CYCLES+2 cycles.
REQ-023 SHALL keep sram_addr at the registered address from SETUP through HOLD. In IDLE it holds the last value.
REQ-024 SHALL never assert sram_oen=0 and sram_dout_en=1 in the same cycle.
REQ-025 SHALL leave requester 1/2 starvation under continuous requester 0 traffic as documented, intended behaviour.

Reset
REQ-026 SHALL, while reset is high, force: state=IDLE, gnt=0, done=0, rdata=0, sram_addr=0, sram_dout=0, sram_dout_en=0, sram_cen=sram_oen=sram_wen=1, busy=0, round-robin pointer favouring requester 1.
REQ-027 SHALL abort any in-flight transaction when reset is asserted mid-operation: no done pulse, and SRAM controls inactive from the cycle after reset is sampled.

Structure
REQ-028 SHALL define in package scarf_sram_pkg: SRAM_AW=19, SRAM_DW=8, NUM_REQ=3, and the state enum.
REQ-029 SHALL place the priority plus round-robin selection in sub-module scarf_sram_prio_arb. It is combinational: it takes req and the pointer and returns a one-hot winner.

Verification (ACCESS_CYCLES=4, gnt at cycle T)
REQ-030 Write: req[1] with addr 0x12345, wdata 0xA5 -> gnt[1] at T; sram_wen=0 at T+2..T+5; sram_dout_en=1 at T+2..T+6; done[1] at T+6; SRAM model holds 0xA5 at 0x12345.
REQ-031 Read: req[2] reading addr 0x00010, model returns 0x3C -> sram_oen=0 at T+2..T+5; done[2] at T+6 with rdata=0x3C.
REQ-032 Priority: req[2:0]=3'b111 held, each dropped after its own gnt -> grants in order 0, 1, 2 at T, T+6, T+12, with no idle cycle between transactions.
REQ-033 Round-robin: req[1] and req[2] held high continuously after reset -> grants alternate 1, 2, 1, 2.
REQ-034 Pre-emption: req[0] rises during requester 1's ACCESS while req[2] is pending -> requester 0 is granted in HOLD, ahead of requester 2.
REQ-035 Reset: reset asserted in the 2nd ACCESS cycle of a write -> next cycle cen/oen/wen=1, dout_en=0, no done. A req held high through reset is granted in the first IDLE cycle after release.

Source files
------------

// File: rtl/scarf_sram_pkg.sv
// Shared types and constants for the SCARF external SRAM arbiter.
// Address/data widths, requester count and the controller state encoding.
package scarf_sram_pkg;

    localparam int SRAM_AW = 19;
    localparam int SRAM_DW = 8;
    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    // Index of the set bit in a one-hot requester vector (0 when empty).
    function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scarf_sram_prio_arb.sv
// Combinational winner select: requester 0 wins outright, requesters 1/2
// share by a round-robin pointer (ptr=0 favours 1, ptr=1 favours 2).
module scarf_sram_prio_arb
    import scarf_sram_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] win
);

    // Fixed priority for requester 0, pointer tie-break between 1 and 2.
    always_comb begin
        win = '0;
        if (req[0]) begin
            win = 3'b001;
        end else if (req[1] && req[2]) begin
            win = ptr ? 3'b100 : 3'b010;
        end else if (req[1]) begin
            win = 3'b010;
        end else if (req[2]) begin
            win = 3'b100;
        end
    end

endmodule

// File: rtl/scarf_sram_arbiter.sv
// Three-port arbiter and strobe sequencer for the asynchronous external SRAM.
// Each transaction runs SETUP, ACCESS (ACCESS_CYCLES long) and HOLD.
module scarf_sram_arbiter
    import scarf_sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                req_rnw,
    input  logic [NUM_REQ-1:0][SRAM_AW-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][SRAM_DW-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                done,
    output logic [SRAM_DW-1:0]                rdata,
    input  logic [SRAM_DW-1:0]                sram_din,
    output logic [SRAM_DW-1:0]                sram_dout,
    output logic                              sram_dout_en,
    output logic [SRAM_AW-1:0]                sram_addr,
    output logic                              sram_cen,
    output logic                              sram_oen,
    output logic                              sram_wen,
    output logic                              busy
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t               state;
    logic [3:0]           cnt;
    logic                 rr_ptr;
    logic                 rnw_q;
    logic [NUM_REQ-1:0]   owner;
    logic [NUM_REQ-1:0]   win;
    logic [1:0]           widx;
    logic                 arb_ok;

    scarf_sram_prio_arb u_prio (
        .req (req),
        .ptr (rr_ptr),
        .win (win)
    );

    assign arb_ok = !reset && (state == IDLE || state == HOLD);
    assign gnt    = arb_ok ? win : '0;
    assign widx   = onehot_idx(win);
    assign busy   = (state != IDLE);

    // Sequencer: outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= 1'b0;
            rnw_q        <= 1'b1;
            owner        <= '0;
            done         <= '0;
            rdata        <= '0;
            sram_addr    <= '0;
            sram_dout    <= '0;
            sram_dout_en <= 1'b0;
            sram_cen     <= 1'b1;
            sram_oen     <= 1'b1;
            sram_wen     <= 1'b1;
        end else begin
            done <= '0;
            unique case (state)
                IDLE, HOLD: begin
                    sram_oen     <= 1'b1;
                    sram_wen     <= 1'b1;
                    sram_dout_en <= 1'b0;
                    if (|win) begin
                        state     <= SETUP;
                        rnw_q     <= req_rnw[widx];
                        sram_addr <= req_addr[widx];
                        sram_dout <= req_wdata[widx];
                        owner     <= win;
                        sram_cen  <= 1'b0;
                        if (win[1]) begin
                            rr_ptr <= 1'b1;
                        end else if (win[2]) begin
                            rr_ptr <= 1'b0;
                        end
                    end else begin
                        state    <= IDLE;
                        sram_cen <= 1'b1;
                    end
                end
                SETUP: begin
                    state        <= ACCESS;
                    cnt          <= CNT_LOAD;
                    sram_oen     <= !rnw_q;
                    sram_wen     <= rnw_q;
                    sram_dout_en <= !rnw_q;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state    <= HOLD;
                        sram_oen <= 1'b1;
                        sram_wen <= 1'b1;
                        done     <= owner;
                        if (rnw_q) rdata <= sram_din;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scarf_sram_arbiter.sv
// Randomized scoreboard bench for scarf_sram_arbiter with an SRAM model
// and a transaction-level reference of arbitration and timing.
module tb_scarf_sram_arbiter;
    import scarf_sram_pkg::*;

    localparam int AC  = 4;
    localparam int LAT = AC + 2;

    logic                            clk;
    logic                            reset;
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              req_rnw;
    logic [NUM_REQ-1:0][SRAM_AW-1:0] req_addr;
    logic [NUM_REQ-1:0][SRAM_DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]              gnt;
    logic [NUM_REQ-1:0]              done;
    logic [SRAM_DW-1:0]              rdata;
    logic [SRAM_DW-1:0]              sram_din;
    logic [SRAM_DW-1:0]              sram_dout;
    logic                            sram_dout_en;
    logic [SRAM_AW-1:0]              sram_addr;
    logic                            sram_cen;
    logic                            sram_oen;
    logic                            sram_wen;
    logic                            busy;

    scarf_sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_rnw      (req_rnw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .rdata        (rdata),
        .sram_din     (sram_din),
        .sram_dout    (sram_dout),
        .sram_dout_en (sram_dout_en),
        .sram_addr    (sram_addr),
        .sram_cen     (sram_cen),
        .sram_oen     (sram_oen),
        .sram_wen     (sram_wen),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         owner;
        bit         rnw;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] sram_mem[int];
    logic [7:0] ref_mem[int];
    int         gnt_log[$];

    // Reference requester and arbiter state
    bit          pend[3];
    bit          p_rnw[3];
    logic [18:0] p_addr[3];
    logic [7:0]  p_wd[3];
    bit          have_gnt;
    int          last_gnt;
    bit          cur_rnw;
    logic [18:0] cur_addr;
    logic [7:0]  cur_wd;
    int          last12;
    bit          mon_en = 1'b0;

    function automatic logic [7:0] init_val(int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(int a);
        return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
    endfunction

    function automatic logic [7:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // SRAM device model on the pins
    always @(posedge clk) begin
        if (!sram_cen && !sram_wen && sram_dout_en)
            sram_mem[int'(sram_addr)] = sram_dout;
    end

    always @(negedge clk) begin
        sram_din = (!sram_cen && !sram_oen) ? mem_rd(int'(sram_addr)) : 8'h00;
    end

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && !reset) begin
            chk("oen_douten_clash", 32'(!sram_oen && sram_dout_en), 0);
            if (done != 0) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(done), 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_owner", 32'(done), 32'(1) << e.owner);
                    chk("done_cycle", cyc, e.due);
                    if (e.rnw) chk("rdata", 32'(rdata), 32'(e.data));
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                chk("done_missing", 0, 32'(1) << e.owner);
            end
        end
    end

    task automatic model_reset();
        have_gnt = 1'b0;
        last_gnt = 0;
        cur_rnw  = 1'b1;
        cur_addr = '0;
        cur_wd   = '0;
        last12   = 2;
    endtask

    task automatic new_req(int i);
        pend[i]   = 1'b1;
        p_rnw[i]  = 1'($urandom_range(0, 1));
        p_addr[i] = 19'($urandom_range(0, 15));
        p_wd[i]   = 8'($urandom);
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            req[i]       = pend[i];
            req_rnw[i]   = p_rnw[i];
            req_addr[i]  = p_addr[i];
            req_wdata[i] = p_wd[i];
        end
    endtask

    // Per-cycle expectation of pins and grant from the transaction timeline
    task automatic check_cycle();
        int       d;
        int       w;
        bit       in_txn;
        bit       acc;
        bit       arb;
        exp_t     e;
        logic [2:0] eg;
        d      = have_gnt ? cyc - last_gnt : 1000;
        in_txn = (d >= 1 && d <= LAT);
        acc    = (d >= 2 && d <= LAT - 1);
        chk("busy", 32'(busy), 32'(in_txn));
        chk("cen", 32'(sram_cen), 32'(!in_txn));
        chk("oen", 32'(sram_oen), 32'(!(acc && cur_rnw)));
        chk("wen", 32'(sram_wen), 32'(!(acc && !cur_rnw)));
        chk("dout_en", 32'(sram_dout_en), 32'(!cur_rnw && d >= 2 && d <= LAT));
        chk("addr", 32'(sram_addr), 32'(cur_addr));
        if (!cur_rnw && d >= 2 && d <= LAT)
            chk("dout", 32'(sram_dout), 32'(cur_wd));
        arb = !have_gnt || d >= LAT;
        w = -1;
        if (arb) begin
            if (pend[0]) w = 0;
            else if (pend[1] && pend[2]) w = (last12 == 1) ? 2 : 1;
            else if (pend[1]) w = 1;
            else if (pend[2]) w = 2;
        end
        eg = (w < 0) ? 3'b000 : 3'(1 << w);
        chk("gnt", 32'(gnt), 32'(eg));
        if (w >= 0) begin
            e.owner = w;
            e.rnw   = p_rnw[w];
            e.data  = ref_rd(int'(p_addr[w]));
            e.due   = cyc + LAT;
            sb.push_back(e);
            if (!p_rnw[w]) ref_mem[int'(p_addr[w])] = p_wd[w];
            have_gnt = 1'b1;
            last_gnt = cyc;
            cur_rnw  = p_rnw[w];
            cur_addr = p_addr[w];
            cur_wd   = p_wd[w];
            if (w > 0) last12 = w;
            gnt_log.push_back(w);
            pend[w] = 1'b0;
        end
    endtask

    // mode 0: no new requests, 1: req 1/2 always re-request, 2: random
    task automatic gen(int mode);
        if (mode == 1) begin
            if (!pend[1]) new_req(1);
            if (!pend[2]) new_req(2);
        end else if (mode == 2) begin
            if (!pend[0] && $urandom_range(0, 99) < 6) new_req(0);
            if (!pend[1] && $urandom_range(0, 99) < 25) new_req(1);
            if (!pend[2] && $urandom_range(0, 99) < 25) new_req(2);
        end
    endtask

    task automatic step(int mode);
        @(negedge clk);
        check_cycle();
        gen(mode);
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        int b;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; p_rnw[i] = 1'b1; p_addr[i] = '0; p_wd[i] = '0;
        end
        drive();
        model_reset();
        sram_mem[32'h10] = 8'h3C;
        ref_mem[32'h10]  = 8'h3C;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_dout", 32'(sram_dout), 0);
        chk("rst_dout_en", 32'(sram_dout_en), 0);
        chk("rst_cen", 32'(sram_cen), 1);
        chk("rst_oen", 32'(sram_oen), 1);
        chk("rst_wen", 32'(sram_wen), 1);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed write then read
        pend[1] = 1'b1; p_rnw[1] = 1'b0; p_addr[1] = 19'h12345; p_wd[1] = 8'hA5;
        drive();
        repeat (10) step(0);
        pend[2] = 1'b1; p_rnw[2] = 1'b1; p_addr[2] = 19'h00010;
        drive();
        repeat (10) step(0);

        // All three at once: 0, 1, 2 back to back
        b = gnt_log.size();
        for (int i = 0; i < 3; i++) new_req(i);
        drive();
        repeat (24) step(0);
        chk("prio_first", gnt_log[b], 0);
        chk("prio_second", gnt_log[b+1], 1);
        chk("prio_third", gnt_log[b+2], 2);

        // Round-robin with 1 and 2 permanently requesting
        b = gnt_log.size();
        repeat (30) step(1);
        repeat (16) step(0);
        chk("rr_a", gnt_log[b] + gnt_log[b+1], 3);
        chk("rr_b", gnt_log[b+1] + gnt_log[b+2], 3);

        // Requester 0 arrives mid-access while 2 waits
        b = gnt_log.size();
        new_req(1);
        drive();
        step(0);
        step(0);
        step(0);
        new_req(0);
        new_req(2);
        drive();
        repeat (20) step(0);
        chk("preempt_first", gnt_log[b], 1);
        chk("preempt_second", gnt_log[b+1], 0);
        chk("preempt_third", gnt_log[b+2], 2);

        // Random traffic, then drain
        repeat (600) step(2);
        repeat (40) step(0);
        chk("sb_empty", sb.size(), 0);

        // Reset in the second ACCESS cycle of a write
        pend[1] = 1'b1; p_rnw[1] = 1'b0; p_addr[1] = 19'h7FFFF; p_wd[1] = 8'h99;
        drive();
        step(0);
        pend[2] = 1'b1; p_rnw[2] = 1'b1; p_addr[2] = 19'h00010;
        drive();
        step(0);
        step(0);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rstmid_gnt", 32'(gnt), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid_cen", 32'(sram_cen), 1);
        chk("rstmid_oen", 32'(sram_oen), 1);
        chk("rstmid_wen", 32'(sram_wen), 1);
        chk("rstmid_dout_en", 32'(sram_dout_en), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_rdata", 32'(rdata), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        sram_mem.delete(32'h7FFFF);
        ref_mem.delete(32'h7FFFF);
        b = gnt_log.size();
        repeat (12) step(0);
        chk("post_reset_gnt", gnt_log[b], 2);
        chk("post_reset_sb", sb.size(), 0);

        foreach (ref_mem[a]) chk("mem", 32'(mem_rd(a)), 32'(ref_mem[a]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
